// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apu_pkg
// Description : Register offsets, read masks and NR52 constant bits for the
//               sound-block register file.
// Revision    : 1.0 - initial release
// ============================================================================
package apu_pkg;

    localparam logic [7:0] c_OFF_NR10 = 8'd0;
    localparam logic [7:0] c_OFF_NR11 = 8'd1;
    localparam logic [7:0] c_OFF_NR12 = 8'd2;
    localparam logic [7:0] c_OFF_NR13 = 8'd3;
    localparam logic [7:0] c_OFF_NR14 = 8'd4;
    localparam logic [7:0] c_OFF_NR21 = 8'd6;
    localparam logic [7:0] c_OFF_NR22 = 8'd7;
    localparam logic [7:0] c_OFF_NR23 = 8'd8;
    localparam logic [7:0] c_OFF_NR24 = 8'd9;
    localparam logic [7:0] c_OFF_NR50 = 8'd20;
    localparam logic [7:0] c_OFF_NR51 = 8'd21;
    localparam logic [7:0] c_OFF_NR52 = 8'd22;

    localparam logic [7:0] c_MASK_NR10     = 8'h80;
    localparam logic [7:0] c_MASK_NRX1     = 8'h3F;
    localparam logic [7:0] c_MASK_NRX2     = 8'h00;
    localparam logic [7:0] c_MASK_NRX3     = 8'hFF;
    localparam logic [7:0] c_MASK_NRX4     = 8'hBF;
    localparam logic [7:0] c_MASK_NR50     = 8'h00;
    localparam logic [7:0] c_MASK_NR51     = 8'h00;
    localparam logic [7:0] c_MASK_UNMAPPED = 8'hFF;

    localparam logic [2:0] c_NR52_FILL = 3'b111;
    localparam logic [1:0] c_NR52_ZERO = 2'b00;

endpackage
`default_nettype wire

// File: rtl/apu_sq_regs.sv
`default_nettype none
// ============================================================================
// Module      : apu_sq_regs
// Description : One pulse channel's NRx1..NRx4 storage, strobes and read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module apu_sq_regs
    import apu_pkg::*;
#(
    parameter logic [7:0] OFF_X1 = c_OFF_NR11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,      // qualified by address window and power
    input  logic        clr,
    input  logic [7:0]  off,
    input  logic [7:0]  wdata,
    output logic        rd_hit,
    output logic [7:0]  rd_val,
    output logic [1:0]  duty,
    output logic [5:0]  lenLoad,
    output logic [3:0]  startVol,
    output logic        envAdd,
    output logic [2:0]  period,
    output logic [10:0] freq,
    output logic        lenEnable,
    output logic        trigger,
    output logic        lenStb
);

    localparam logic [7:0] c_OFF_X2 = OFF_X1 + 8'd1;
    localparam logic [7:0] c_OFF_X3 = OFF_X1 + 8'd2;
    localparam logic [7:0] c_OFF_X4 = OFF_X1 + 8'd3;

    logic [1:0]  r_duty;
    logic [5:0]  r_len_load;
    logic [3:0]  r_start_vol;
    logic        r_env_add;
    logic [2:0]  r_period;
    logic [10:0] r_freq;
    logic        r_len_enable;
    logic        r_trigger;
    logic        r_len_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty       <= 2'd0;
            r_len_load   <= 6'd0;
            r_start_vol  <= 4'd0;
            r_env_add    <= 1'b0;
            r_period     <= 3'd0;
            r_freq       <= 11'd0;
            r_len_enable <= 1'b0;
            r_trigger    <= 1'b0;
            r_len_stb    <= 1'b0;
        end else begin
            r_trigger <= 1'b0;
            r_len_stb <= 1'b0;
            if (clr) begin
                r_duty       <= 2'd0;
                r_len_load   <= 6'd0;
                r_start_vol  <= 4'd0;
                r_env_add    <= 1'b0;
                r_period     <= 3'd0;
                r_freq       <= 11'd0;
                r_len_enable <= 1'b0;
            end else if (wr_en) begin
                case (off)
                    OFF_X1: begin
                        r_duty     <= wdata[7:6];
                        r_len_load <= wdata[5:0];
                        r_len_stb  <= 1'b1;
                    end
                    c_OFF_X2: begin
                        r_start_vol <= wdata[7:4];
                        r_env_add   <= wdata[3];
                        r_period    <= wdata[2:0];
                    end
                    c_OFF_X3: r_freq[7:0] <= wdata;
                    c_OFF_X4: begin
                        // Trigger bit is an action, not state
                        r_trigger     <= wdata[7];
                        r_len_enable  <= wdata[6];
                        r_freq[10:8]  <= wdata[2:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_hit = 1'b1;
        rd_val = c_MASK_UNMAPPED;
        case (off)
            OFF_X1:   rd_val = {r_duty, r_len_load} | c_MASK_NRX1;
            c_OFF_X2: rd_val = {r_start_vol, r_env_add, r_period} | c_MASK_NRX2;
            c_OFF_X3: rd_val = r_freq[7:0] | c_MASK_NRX3;
            c_OFF_X4: rd_val = {1'b0, r_len_enable, 3'b000, r_freq[10:8]} | c_MASK_NRX4;
            default:  rd_hit = 1'b0;
        endcase
    end

    assign duty      = r_duty;
    assign lenLoad   = r_len_load;
    assign startVol  = r_start_vol;
    assign envAdd    = r_env_add;
    assign period    = r_period;
    assign freq      = r_freq;
    assign lenEnable = r_len_enable;
    assign trigger   = r_trigger;
    assign lenStb    = r_len_stb;

endmodule
`default_nettype wire

// File: rtl/apu_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : apu_reg_file
// Description : CPU-facing sound register file (FF10..FF26 window).
// Revision    : 1.0 - initial release
// ============================================================================
module apu_reg_file
    import apu_pkg::*;
#(
    parameter logic [7:0] BASE = 8'h10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        sq1_active,
    input  logic        sq2_active,
    output logic [2:0]  sq1_swpPd,
    output logic        sq1_negate,
    output logic [2:0]  sq1_shift,
    output logic [1:0]  sq1_duty,
    output logic [5:0]  sq1_lenLoad,
    output logic [3:0]  sq1_startVol,
    output logic        sq1_envAdd,
    output logic [2:0]  sq1_period,
    output logic [10:0] sq1_freq,
    output logic        sq1_lenEnable,
    output logic        sq1_trigger,
    output logic        sq1_lenStb,
    output logic [1:0]  sq2_duty,
    output logic [5:0]  sq2_lenLoad,
    output logic [3:0]  sq2_startVol,
    output logic        sq2_envAdd,
    output logic [2:0]  sq2_period,
    output logic [10:0] sq2_freq,
    output logic        sq2_lenEnable,
    output logic        sq2_trigger,
    output logic        sq2_lenStb,
    output logic [2:0]  vol_l,
    output logic [2:0]  vol_r,
    output logic        vin_l,
    output logic        vin_r,
    output logic [7:0]  pan,
    output logic        power
);

    logic [7:0] w_off;
    logic       w_in_win;
    logic       w_wr_nr52;
    logic       w_wr_fld;
    logic       w_pwr_off;
    logic       w_sq1_hit;
    logic       w_sq2_hit;
    logic [7:0] w_sq1_rd;
    logic [7:0] w_sq2_rd;
    logic [7:0] w_rd_val;

    logic [6:0] r_nr10;
    logic [7:0] r_nr50;
    logic [7:0] r_nr51;
    logic       r_power;
    logic [7:0] r_rdata;

    assign w_off     = addr - BASE;
    assign w_in_win  = (addr >= BASE) && (w_off <= c_OFF_NR52);
    assign w_wr_nr52 = wr_en && w_in_win && (w_off == c_OFF_NR52);
    // Field writes are blocked while powered down; NR52 itself stays writable
    assign w_wr_fld  = wr_en && w_in_win && r_power && (w_off != c_OFF_NR52);
    assign w_pwr_off = w_wr_nr52 && !wdata[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nr10  <= 7'd0;
            r_nr50  <= 8'd0;
            r_nr51  <= 8'd0;
            r_power <= 1'b1;
            r_rdata <= 8'd0;
        end else begin
            if (rd_en) r_rdata <= w_rd_val;
            if (w_pwr_off) begin
                r_nr10 <= 7'd0;
                r_nr50 <= 8'd0;
                r_nr51 <= 8'd0;
            end else if (w_wr_fld) begin
                case (w_off)
                    c_OFF_NR10: r_nr10 <= wdata[6:0];
                    c_OFF_NR50: r_nr50 <= wdata;
                    c_OFF_NR51: r_nr51 <= wdata;
                    default: ;
                endcase
            end
            if (w_wr_nr52) r_power <= wdata[7];
        end
    end

    always_comb begin
        w_rd_val = c_MASK_UNMAPPED;
        if (w_in_win) begin
            case (w_off)
                c_OFF_NR10: w_rd_val = {1'b0, r_nr10} | c_MASK_NR10;
                c_OFF_NR50: w_rd_val = r_nr50 | c_MASK_NR50;
                c_OFF_NR51: w_rd_val = r_nr51 | c_MASK_NR51;
                c_OFF_NR52: w_rd_val = {r_power, c_NR52_FILL, c_NR52_ZERO, sq2_active, sq1_active};
                default: begin
                    if (w_sq1_hit)      w_rd_val = w_sq1_rd;
                    else if (w_sq2_hit) w_rd_val = w_sq2_rd;
                end
            endcase
        end
    end

    apu_sq_regs #(.OFF_X1(c_OFF_NR11)) u_sq1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (w_wr_fld),
        .clr       (w_pwr_off),
        .off       (w_off),
        .wdata     (wdata),
        .rd_hit    (w_sq1_hit),
        .rd_val    (w_sq1_rd),
        .duty      (sq1_duty),
        .lenLoad   (sq1_lenLoad),
        .startVol  (sq1_startVol),
        .envAdd    (sq1_envAdd),
        .period    (sq1_period),
        .freq      (sq1_freq),
        .lenEnable (sq1_lenEnable),
        .trigger   (sq1_trigger),
        .lenStb    (sq1_lenStb)
    );

    apu_sq_regs #(.OFF_X1(c_OFF_NR21)) u_sq2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (w_wr_fld),
        .clr       (w_pwr_off),
        .off       (w_off),
        .wdata     (wdata),
        .rd_hit    (w_sq2_hit),
        .rd_val    (w_sq2_rd),
        .duty      (sq2_duty),
        .lenLoad   (sq2_lenLoad),
        .startVol  (sq2_startVol),
        .envAdd    (sq2_envAdd),
        .period    (sq2_period),
        .freq      (sq2_freq),
        .lenEnable (sq2_lenEnable),
        .trigger   (sq2_trigger),
        .lenStb    (sq2_lenStb)
    );

    assign rdata      = r_rdata;
    assign sq1_swpPd  = r_nr10[6:4];
    assign sq1_negate = r_nr10[3];
    assign sq1_shift  = r_nr10[2:0];
    assign vin_l      = r_nr50[7];
    assign vol_l      = r_nr50[6:4];
    assign vin_r      = r_nr50[3];
    assign vol_r      = r_nr50[2:0];
    assign pan        = r_nr51;
    assign power      = r_power;

endmodule
`default_nettype wire

// File: tb/tb_apu_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_apu_reg_file
// Description : Self-checking bench for apu_reg_file: byte-map model plus
//               directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apu_reg_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        sq1_active = 1'b0;
    logic        sq2_active = 1'b0;
    logic [2:0]  sq1_swpPd;
    logic        sq1_negate;
    logic [2:0]  sq1_shift;
    logic [1:0]  sq1_duty, sq2_duty;
    logic [5:0]  sq1_lenLoad, sq2_lenLoad;
    logic [3:0]  sq1_startVol, sq2_startVol;
    logic        sq1_envAdd, sq2_envAdd;
    logic [2:0]  sq1_period, sq2_period;
    logic [10:0] sq1_freq, sq2_freq;
    logic        sq1_lenEnable, sq2_lenEnable;
    logic        sq1_trigger, sq2_trigger;
    logic        sq1_lenStb, sq2_lenStb;
    logic [2:0]  vol_l, vol_r;
    logic        vin_l, vin_r;
    logic [7:0]  pan;
    logic        power;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    apu_reg_file #(.BASE(8'h10)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .sq1_active(sq1_active), .sq2_active(sq2_active),
        .sq1_swpPd(sq1_swpPd), .sq1_negate(sq1_negate), .sq1_shift(sq1_shift),
        .sq1_duty(sq1_duty), .sq1_lenLoad(sq1_lenLoad), .sq1_startVol(sq1_startVol),
        .sq1_envAdd(sq1_envAdd), .sq1_period(sq1_period), .sq1_freq(sq1_freq),
        .sq1_lenEnable(sq1_lenEnable), .sq1_trigger(sq1_trigger), .sq1_lenStb(sq1_lenStb),
        .sq2_duty(sq2_duty), .sq2_lenLoad(sq2_lenLoad), .sq2_startVol(sq2_startVol),
        .sq2_envAdd(sq2_envAdd), .sq2_period(sq2_period), .sq2_freq(sq2_freq),
        .sq2_lenEnable(sq2_lenEnable), .sq2_trigger(sq2_trigger), .sq2_lenStb(sq2_lenStb),
        .vol_l(vol_l), .vol_r(vol_r), .vin_l(vin_l), .vin_r(vin_r), .pan(pan), .power(power)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- byte-level model of the register map ----------------
    logic [7:0] m_reg [0:22];
    logic       m_power;
    logic [7:0] m_rdata;
    logic       m_trig1, m_trig2, m_ls1, m_ls2;
    wire  [7:0] tb_off = addr - 8'h10;
    wire        tb_in  = (addr >= 8'h10) && (addr <= 8'h26);

    function automatic logic [7:0] wmask(input logic [7:0] o);
        case (o)
            8'd0:                   return 8'h7F;
            8'd1, 8'd2, 8'd3:       return 8'hFF;
            8'd6, 8'd7, 8'd8:       return 8'hFF;
            8'd4, 8'd9:             return 8'h47;
            8'd20, 8'd21:           return 8'hFF;
            default:                return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rmask(input logic [7:0] o);
        case (o)
            8'd0:       return 8'h80;
            8'd1, 8'd6: return 8'h3F;
            8'd2, 8'd7: return 8'h00;
            8'd3, 8'd8: return 8'hFF;
            8'd4, 8'd9: return 8'hBF;
            default:    return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        logic [7:0] o;
        o = a - 8'h10;
        if (a < 8'h10 || a > 8'h26) return 8'hFF;
        if (o == 8'd22) return {m_power, 3'b111, 2'b00, sq2_active, sq1_active};
        if (wmask(o) == 8'h00) return 8'hFF;
        return m_reg[o] | rmask(o);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 23; i++) m_reg[i] <= 8'h00;
            m_power <= 1'b1;
            m_rdata <= 8'h00;
            m_trig1 <= 1'b0; m_trig2 <= 1'b0; m_ls1 <= 1'b0; m_ls2 <= 1'b0;
        end else begin
            if (rd_en) m_rdata <= exp_read(addr);
            m_trig1 <= 1'b0; m_trig2 <= 1'b0; m_ls1 <= 1'b0; m_ls2 <= 1'b0;
            if (wr_en && tb_in) begin
                if (tb_off == 8'd22) begin
                    m_power <= wdata[7];
                    if (!wdata[7]) for (int i = 0; i < 22; i++) m_reg[i] <= 8'h00;
                end else if (m_power && wmask(tb_off) != 8'h00) begin
                    m_reg[tb_off] <= wdata & wmask(tb_off);
                    if (tb_off == 8'd1) m_ls1 <= 1'b1;
                    if (tb_off == 8'd6) m_ls2 <= 1'b1;
                    if (tb_off == 8'd4 && wdata[7]) m_trig1 <= 1'b1;
                    if (tb_off == 8'd9 && wdata[7]) m_trig2 <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rdata", {24'd0, rdata}, {24'd0, m_rdata});
            chk("power", {31'd0, power}, {31'd0, m_power});
            chk("strobes", {28'd0, sq1_trigger, sq1_lenStb, sq2_trigger, sq2_lenStb},
                {28'd0, m_trig1, m_ls1, m_trig2, m_ls2});
            chk("sq1_fields",
                {sq1_swpPd, sq1_negate, sq1_shift, sq1_duty, sq1_lenLoad, sq1_startVol,
                 sq1_envAdd, sq1_period, sq1_lenEnable},
                {m_reg[0][6:4], m_reg[0][3], m_reg[0][2:0], m_reg[1][7:6], m_reg[1][5:0],
                 m_reg[2][7:4], m_reg[2][3], m_reg[2][2:0], m_reg[4][6]});
            chk("sq1_freq", {21'd0, sq1_freq}, {21'd0, m_reg[4][2:0], m_reg[3]});
            chk("sq2_fields",
                {sq2_duty, sq2_lenLoad, sq2_startVol, sq2_envAdd, sq2_period, sq2_lenEnable, sq2_freq},
                {m_reg[6][7:6], m_reg[6][5:0], m_reg[7][7:4], m_reg[7][3], m_reg[7][2:0],
                 m_reg[9][6], m_reg[9][2:0], m_reg[8]});
            chk("mixer", {16'd0, vin_l, vol_l, vin_r, vol_r, pan},
                {16'd0, m_reg[20][7], m_reg[20][6:4], m_reg[20][3], m_reg[20][2:0], m_reg[21]});
        end
    end

    // ---------------- directed stimulus (called at a falling edge) ----------------
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        v = rdata;
    endtask

    logic [7:0] v;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_rdata", {24'd0, rdata}, 32'h00);
        chk("reset_power", {31'd0, power}, 32'd1);

        rd(8'h26, v); chk("nr52_reset", {24'd0, v}, 32'hF0);
        rd(8'h13, v); chk("nr13_reset", {24'd0, v}, 32'hFF);

        wr(8'h11, 8'hC5);
        chk("nr11_duty", {30'd0, sq1_duty}, 32'h3);
        chk("nr11_len", {26'd0, sq1_lenLoad}, 32'h05);
        chk("nr11_stb_hi", {31'd0, sq1_lenStb}, 32'd1);
        @(negedge clk);
        chk("nr11_stb_lo", {31'd0, sq1_lenStb}, 32'd0);
        rd(8'h11, v); chk("nr11_read", {24'd0, v}, 32'hFF);

        wr(8'h13, 8'h34);
        wr(8'h14, 8'hC2);
        chk("nr14_freq", {21'd0, sq1_freq}, 32'h234);
        chk("nr14_lenen", {31'd0, sq1_lenEnable}, 32'd1);
        chk("nr14_trig_hi", {31'd0, sq1_trigger}, 32'd1);
        @(negedge clk);
        chk("nr14_trig_lo", {31'd0, sq1_trigger}, 32'd0);
        rd(8'h14, v); chk("nr14_read", {24'd0, v}, 32'hFF);

        wr(8'h10, 8'h5A);
        rd(8'h10, v); chk("nr10_read", {24'd0, v}, 32'hDA);

        wr(8'h12, 8'hA3);
        chk("nr12_vol", {28'd0, sq1_startVol}, 32'hA);
        wr(8'h26, 8'h00);
        wr(8'h12, 8'h55);   // lands the cycle right after power-off
        chk("pwroff_vol", {28'd0, sq1_startVol}, 32'h0);
        chk("pwroff_power", {31'd0, power}, 32'd0);
        rd(8'h12, v); chk("pwroff_nr12", {24'd0, v}, 32'h00);
        wr(8'h14, 8'h80);
        chk("pwroff_no_trig", {31'd0, sq1_trigger}, 32'd0);
        wr(8'h26, 8'h80);
        rd(8'h12, v); chk("pwron_nr12", {24'd0, v}, 32'h00);

        sq2_active = 1'b1;
        rd(8'h26, v); chk("nr52_active", {24'd0, v}, 32'hF2);

        wr(8'h25, 8'h11);
        wr(8'h24, 8'hB5);
        chk("nr50_fields", {24'd0, vin_l, vol_l, vin_r, vol_r}, 32'hB5);
        rd_en = 1'b1; wr_en = 1'b1; addr = 8'h25; wdata = 8'h22;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        chk("rw_same_old", {24'd0, rdata}, 32'h11);
        chk("rw_same_pan", {24'd0, pan}, 32'h22);
        rd(8'h25, v); chk("rw_same_new", {24'd0, v}, 32'h22);

        rd(8'h15, v); chk("unmapped_15", {24'd0, v}, 32'hFF);
        rd(8'h1C, v); chk("unmapped_1c", {24'd0, v}, 32'hFF);
        rd(8'h30, v); chk("outside_30", {24'd0, v}, 32'hFF);
        wr(8'h15, 8'h12);
        wr(8'h30, 8'h12);

        wr(8'h18, 8'h9C);
        wr(8'h19, 8'h85);
        wr(8'h19, 8'h85);   // back-to-back trigger
        chk("nr24_freq", {21'd0, sq2_freq}, 32'h59C);
        chk("nr24_trig", {31'd0, sq2_trigger}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_trig_drop", {31'd0, sq2_trigger}, 32'd0);
        chk("rst_freq", {21'd0, sq2_freq}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'h00);
        chk("rst_pan", {24'd0, pan}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(8'h17, v); chk("post_rst_nr22", {24'd0, v}, 32'h00);
        rd(8'h19, v); chk("post_rst_nr24", {24'd0, v}, 32'hBF);
        rd(8'h24, v); chk("post_rst_nr50", {24'd0, v}, 32'h00);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
